mips_multicycle_control: RTL

- Main control FSM for the multicycle MIPS datapath. It is the producer side of the ALU-control interface.
- It decodes the IR opcode and sequences the datapath through fetch, decode, execute, memory and writeback.
- It drives `alu_op[1:0]` into `alu_control`, which combines it with funct to form `aluctrl`.
- It also drives every mux select and write enable in the datapath.

---
 rtl/mips_multicycle_control_pkg.sv | 70 +++++++
 rtl/mips_multicycle_control_output_decode.sv | 119 +++++++++++
 rtl/mips_multicycle_control.sv | 97 +++++++++
 3 files changed

// File: rtl/mips_multicycle_control_pkg.sv
// Shared constants, state encodings and control-word type for the multicycle MIPS control unit.
// Optional feature macro: MIPS_MC_ADDI_EN (adds the addi execute/writeback states).
package mips_multicycle_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // alu_control decodes these; 10 defers to the funct field
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEMADDR   = 4'd2,
    ST_MEMREAD   = 4'd3,
    ST_MEMWB     = 4'd4,
    ST_MEMWRITE  = 4'd5,
    ST_EXECUTE   = 4'd6,
    ST_RCOMPLETE = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_JUMP      = 4'd9,
    ST_ADDIEXEC  = 4'd10,
    ST_ADDIWB    = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       retire;
    logic       illegal_op;
  } ctrl_t;

  // True for every opcode the decoder has a sequence for
  function automatic logic op_is_known(input logic [5:0] op);
    logic known;
    known = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
            (op == OP_BEQ) || (op == OP_J);
`ifdef MIPS_MC_ADDI_EN
    known = known || (op == OP_ADDI);
`endif
    return known;
  endfunction

endpackage

// File: rtl/mips_multicycle_control_output_decode.sv
// Moore output decoder: maps the current state to the datapath control word.
// Reset forces every control to zero. Optional feature macro: MIPS_MC_ADDI_EN.
module mc_output_decode
  import mips_multicycle_control_pkg::*;
(
  input  logic       i_reset,
  input  logic [3:0] i_state,
  input  logic       i_op_known,
  output logic       o_pc_write,
  output logic       o_pc_write_cond,
  output logic       o_i_or_d,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_ir_write,
  output logic       o_mem_to_reg,
  output logic       o_reg_dst,
  output logic       o_reg_write,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_alu_op,
  output logic [1:0] o_pc_source,
  output logic       o_retire,
  output logic       o_illegal_op
);

  ctrl_t w_ctrl;

  always_comb begin
    w_ctrl = '0;
    case (i_state)
      ST_FETCH: begin
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.ir_write  = 1'b1;
        w_ctrl.alu_src_b = SRCB_FOUR;
        w_ctrl.pc_write  = 1'b1;
      end
      ST_DECODE: begin
        w_ctrl.alu_src_b  = SRCB_IMM_SH2;
        w_ctrl.illegal_op = ~i_op_known;
      end
      ST_MEMADDR: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = ALU_OP_ADD;
      end
      ST_MEMREAD: begin
        w_ctrl.mem_read = 1'b1;
        w_ctrl.i_or_d   = 1'b1;
      end
      ST_MEMWB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_ctrl.retire     = 1'b1;
      end
      ST_MEMWRITE: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.i_or_d    = 1'b1;
        w_ctrl.retire    = 1'b1;
      end
      ST_EXECUTE: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_REG;
        w_ctrl.alu_op    = ALU_OP_FUNCT;
      end
      ST_RCOMPLETE: begin
        w_ctrl.reg_dst   = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.retire    = 1'b1;
      end
      ST_BRANCH: begin
        w_ctrl.alu_src_a     = 1'b1;
        w_ctrl.alu_op        = ALU_OP_SUB;
        w_ctrl.pc_write_cond = 1'b1;
        w_ctrl.pc_source     = PCSRC_ALUOUT;
        w_ctrl.retire        = 1'b1;
      end
      ST_JUMP: begin
        w_ctrl.pc_write  = 1'b1;
        w_ctrl.pc_source = PCSRC_JUMP;
        w_ctrl.retire    = 1'b1;
      end
`ifdef MIPS_MC_ADDI_EN
      ST_ADDIEXEC: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = ALU_OP_ADD;
      end
      ST_ADDIWB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.reg_dst    = 1'b0;
        w_ctrl.mem_to_reg = 1'b0;
        w_ctrl.retire     = 1'b1;
      end
`endif
      default: w_ctrl = '0;
    endcase
    // Holding reset must never let a stale state write memory or registers
    if (i_reset) begin
      w_ctrl = '0;
    end
  end

  assign o_pc_write      = w_ctrl.pc_write;
  assign o_pc_write_cond = w_ctrl.pc_write_cond;
  assign o_i_or_d        = w_ctrl.i_or_d;
  assign o_mem_read      = w_ctrl.mem_read;
  assign o_mem_write     = w_ctrl.mem_write;
  assign o_ir_write      = w_ctrl.ir_write;
  assign o_mem_to_reg    = w_ctrl.mem_to_reg;
  assign o_reg_dst       = w_ctrl.reg_dst;
  assign o_reg_write     = w_ctrl.reg_write;
  assign o_alu_src_a     = w_ctrl.alu_src_a;
  assign o_alu_src_b     = w_ctrl.alu_src_b;
  assign o_alu_op        = w_ctrl.alu_op;
  assign o_pc_source     = w_ctrl.pc_source;
  assign o_retire        = w_ctrl.retire;
  assign o_illegal_op    = w_ctrl.illegal_op;

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: state register and opcode-driven sequencing.
// Optional feature macro: MIPS_MC_ADDI_EN (addi executes in ADDIEXEC/ADDIWB instead of trapping).
module mips_multicycle_control
  import mips_multicycle_control_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int STATE_W = 4
)
(
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    opcode,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic               retire,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  state_t     r_state;
  state_t     w_next;
  logic [5:0] w_op;
  logic       w_op_known;

  assign w_op       = 6'(opcode);
  assign w_op_known = op_is_known(w_op);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Opcode is only consulted in DECODE and MEMADDR; other states ignore it
  always_comb begin
    w_next = ST_FETCH;
    case (r_state)
      ST_FETCH: w_next = ST_DECODE;
      ST_DECODE: begin
        case (w_op)
          OP_LW, OP_SW: w_next = ST_MEMADDR;
          OP_RTYPE:     w_next = ST_EXECUTE;
          OP_BEQ:       w_next = ST_BRANCH;
          OP_J:         w_next = ST_JUMP;
`ifdef MIPS_MC_ADDI_EN
          OP_ADDI:      w_next = ST_ADDIEXEC;
`endif
          default:      w_next = ST_FETCH;
        endcase
      end
      ST_MEMADDR:  w_next = (w_op == OP_LW) ? ST_MEMREAD : ST_MEMWRITE;
      ST_MEMREAD:  w_next = ST_MEMWB;
      ST_EXECUTE:  w_next = ST_RCOMPLETE;
`ifdef MIPS_MC_ADDI_EN
      ST_ADDIEXEC: w_next = ST_ADDIWB;
`endif
      default:     w_next = ST_FETCH;
    endcase
  end

  mc_output_decode u_output_decode (
    .i_reset         (reset),
    .i_state         (r_state),
    .i_op_known      (w_op_known),
    .o_pc_write      (pc_write),
    .o_pc_write_cond (pc_write_cond),
    .o_i_or_d        (i_or_d),
    .o_mem_read      (mem_read),
    .o_mem_write     (mem_write),
    .o_ir_write      (ir_write),
    .o_mem_to_reg    (mem_to_reg),
    .o_reg_dst       (reg_dst),
    .o_reg_write     (reg_write),
    .o_alu_src_a     (alu_src_a),
    .o_alu_src_b     (alu_src_b),
    .o_alu_op        (alu_op),
    .o_pc_source     (pc_source),
    .o_retire        (retire),
    .o_illegal_op    (illegal_op)
  );

  assign state = STATE_W'(r_state);

endmodule
